// File: rtl/kl_decode_pkg.sv
// Shared opcode encodings, ctrl_out field offsets and the decoded-instruction bundle
// for decode_stage_sb.
package kl_decode_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDR = 3'b011;
    localparam logic [2:0] OP_STR = 3'b100;
    localparam logic [2:0] OP_ALU = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;
    localparam logic [1:0] MOV_IMM = 2'b10;

    // Bit positions inside ctrl_out; pc sits above asel, opcode above pc.
    localparam int CTRL_WNUM_LSB  = 0;
    localparam int CTRL_WRITE     = 3;
    localparam int CTRL_SHIFT_LSB = 4;
    localparam int CTRL_ALUOP_LSB = 6;
    localparam int CTRL_LOADS     = 8;
    localparam int CTRL_BSEL      = 9;
    localparam int CTRL_ASEL      = 10;
    localparam int CTRL_PC_LSB    = 11;

    localparam int USED_RM = 2;
    localparam int USED_RN = 1;
    localparam int USED_RD = 0;

    typedef struct packed {
        logic [2:0] opcode;
        logic       asel;
        logic       bsel;
        logic       loads;
        logic [1:0] aluop;
        logic [1:0] shift;
        logic       write;
        logic [2:0] writenum;
        logic [2:0] rm;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [2:0] used;
        logic [7:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [15:0] ir);
        dec_t d;
        d = '0;
        d.opcode = ir[15:13];
        case (ir[15:13])
            OP_NOP: d.opcode = OP_NOP;
            OP_MOV: begin
                d.bsel  = 1'b1;
                d.write = 1'b1;
                if (ir[12:11] == MOV_IMM) begin
                    d.asel     = 1'b1;
                    d.writenum = ir[10:8];
                    d.imm      = ir[7:0];
                end else begin
                    d.writenum = ir[7:5];
                    d.shift    = ir[4:3];
                    d.rm       = ir[2:0];
                    d.used     = 3'b100;
                end
            end
            OP_ALU: begin
                d.aluop = ir[12:11];
                d.shift = ir[4:3];
                d.rm    = ir[2:0];
                case (ir[12:11])
                    ALU_ADD, ALU_AND: begin
                        d.rn       = ir[10:8];
                        d.write    = 1'b1;
                        d.writenum = ir[7:5];
                        d.used     = 3'b110;
                    end
                    ALU_CMP: begin
                        d.rn    = ir[10:8];
                        d.loads = 1'b1;
                        d.used  = 3'b110;
                    end
                    ALU_MVN: begin
                        d.write    = 1'b1;
                        d.writenum = ir[7:5];
                        d.used     = 3'b100;
                    end
                    default: d.used = 3'b000;
                endcase
            end
            OP_STR: begin
                d.bsel = 1'b1;
                d.rm   = ir[10:8];
                d.rd   = ir[7:5];
                d.imm  = {{3{ir[4]}}, ir[4:0]};
                d.used = 3'b101;
            end
            OP_LDR: begin
                d.bsel     = 1'b1;
                d.rm       = ir[10:8];
                d.write    = 1'b1;
                d.writenum = ir[7:5];
                d.imm      = {{3{ir[4]}}, ir[4:0]};
                d.used     = 3'b100;
            end
            default: d.used = 3'b000;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/kl_scoreboard.sv
// Per-register count of in-flight writes with same-cycle writeback bypass;
// reports whether the offered instruction must wait.
module kl_scoreboard
    import kl_decode_pkg::*;
#(
    parameter int SB_DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       inc_en,
    input  logic [2:0] inc_num,
    input  logic       wb_valid,
    input  logic [2:0] wb_num,
    input  logic [2:0] used,
    input  logic [2:0] rm,
    input  logic [2:0] rn,
    input  logic [2:0] rd,
    input  logic       write,
    input  logic [2:0] writenum,
    output logic       blocked
);

    localparam int            CW  = $clog2(SB_DEPTH + 1);
    localparam logic [CW-1:0] SAT = CW'(SB_DEPTH);

    logic [CW-1:0] cnt [8];
    logic [CW-1:0] eff [8];
    logic [7:0]    inc;
    logic [7:0]    dec;

    for (genvar r = 0; r < 8; r++) begin : g_reg
        logic [CW-1:0] cnt_q;

        // A writeback against an empty counter is dropped rather than wrapping.
        assign dec[r] = wb_valid && (wb_num == 3'(r)) && (cnt_q != '0);
        assign inc[r] = inc_en && (inc_num == 3'(r));
        assign cnt[r] = cnt_q;
        assign eff[r] = cnt_q - CW'(dec[r]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt_q <= '0;
            else if (flush)
                cnt_q <= '0;
            else if (inc[r] && !dec[r])
                cnt_q <= cnt_q + CW'(1);
            else if (dec[r] && !inc[r])
                cnt_q <= cnt_q - CW'(1);
        end
    end

    assign blocked = (used[USED_RM] && (eff[rm] != '0)) ||
                     (used[USED_RN] && (eff[rn] != '0)) ||
                     (used[USED_RD] && (eff[rd] != '0)) ||
                     (write && (eff[writenum] == SAT));

endmodule

// File: rtl/decode_stage_sb.sv
// Registered 16-bit instruction decoder with write scoreboard and valid/ready output.
// Define KL_DECODE_ILLEGAL_TRAP_EN to add illegal_out for opcodes 001/010/111.
module decode_stage_sb
    import kl_decode_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int DATA_W   = 16,
    parameter int SB_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       ir_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [2:0]        wb_num,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [13+PC_W:0]  ctrl_out,
    output logic [2:0]        num_rm,
    output logic [2:0]        num_rn,
    output logic [2:0]        num_rd,
    output logic [2:0]        used_mask,
    output logic [DATA_W-1:0] sximm,
    output logic              hazard_stall
`ifdef KL_DECODE_ILLEGAL_TRAP_EN
    ,
    output logic              illegal_out
`endif
);

    dec_t             dec_p0;
    dec_t             dec_p1;
    logic [PC_W-1:0]  pc_p1;
    logic             vld_p1;
    logic             sb_block;
    logic             hazard;
    logic             accept;
    logic signed [7:0] imm_s;

    assign dec_p0 = decode(ir_in);

    kl_scoreboard #(
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .inc_en   (accept && dec_p0.write),
        .inc_num  (dec_p0.writenum),
        .wb_valid (wb_valid),
        .wb_num   (wb_num),
        .used     (dec_p0.used),
        .rm       (dec_p0.rm),
        .rn       (dec_p0.rn),
        .rd       (dec_p0.rd),
        .write    (dec_p0.write),
        .writenum (dec_p0.writenum),
        .blocked  (sb_block)
    );

    assign hazard       = in_valid && sb_block;
    assign in_ready     = !flush && !hazard && (!vld_p1 || out_ready);
    assign hazard_stall = hazard && !flush;
    assign accept       = in_valid && in_ready;

    // p0 -> p1: output register, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            dec_p1 <= '0;
            pc_p1  <= '0;
        end else begin
            if (flush)
                vld_p1 <= 1'b0;
            else if (accept)
                vld_p1 <= 1'b1;
            else if (out_ready)
                vld_p1 <= 1'b0;
            if (accept) begin
                dec_p1 <= dec_p0;
                pc_p1  <= pc_in;
            end
        end
    end

`ifdef KL_DECODE_ILLEGAL_TRAP_EN
    logic ill_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ill_p1 <= 1'b0;
        else if (accept)
            ill_p1 <= (ir_in[15:13] == 3'b001) || (ir_in[15:13] == 3'b010) ||
                      (ir_in[15:13] == 3'b111);
    end

    assign illegal_out = ill_p1;
`endif

    always_comb begin
        ctrl_out = '0;
        ctrl_out[CTRL_WNUM_LSB +: 3]     = dec_p1.writenum;
        ctrl_out[CTRL_WRITE]             = dec_p1.write;
        ctrl_out[CTRL_SHIFT_LSB +: 2]    = dec_p1.shift;
        ctrl_out[CTRL_ALUOP_LSB +: 2]    = dec_p1.aluop;
        ctrl_out[CTRL_LOADS]             = dec_p1.loads;
        ctrl_out[CTRL_BSEL]              = dec_p1.bsel;
        ctrl_out[CTRL_ASEL]              = dec_p1.asel;
        ctrl_out[CTRL_PC_LSB +: PC_W]    = pc_p1;
        ctrl_out[CTRL_PC_LSB + PC_W +: 3] = dec_p1.opcode;
    end

    assign imm_s     = dec_p1.imm;
    assign sximm     = DATA_W'(imm_s);
    assign out_valid = vld_p1;
    assign num_rm    = dec_p1.rm;
    assign num_rn    = dec_p1.rn;
    assign num_rd    = dec_p1.rd;
    assign used_mask = dec_p1.used;

endmodule

// File: tb/tb_decode_stage_sb.sv
// Bench for decode_stage_sb: decode table, directed handshake/scoreboard sequences and
// randomized traffic against a behavioural model (honours KL_DECODE_ILLEGAL_TRAP_EN).
module tb_decode_stage_sb;

    localparam int PC_W     = 8;
    localparam int DATA_W   = 16;
    localparam int SB_DEPTH = 3;

    logic clk = 1'b0;
    logic rst, in_valid, flush, wb_valid, out_ready;
    logic in_ready, out_valid, hazard_stall;
    logic [15:0]       ir_in;
    logic [PC_W-1:0]   pc_in;
    logic [2:0]        wb_num;
    logic [13+PC_W:0]  ctrl_out;
    logic [2:0]        num_rm, num_rn, num_rd, used_mask;
    logic [DATA_W-1:0] sximm;
`ifdef KL_DECODE_ILLEGAL_TRAP_EN
    logic illegal_out;
`endif

    always #5 clk = ~clk;

    decode_stage_sb #(.PC_W(PC_W), .DATA_W(DATA_W), .SB_DEPTH(SB_DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ir_in(ir_in),
        .pc_in(pc_in), .flush(flush), .wb_valid(wb_valid), .wb_num(wb_num),
        .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out),
        .num_rm(num_rm), .num_rn(num_rn), .num_rd(num_rd), .used_mask(used_mask),
        .sximm(sximm), .hazard_stall(hazard_stall)
`ifdef KL_DECODE_ILLEGAL_TRAP_EN
        , .illegal_out(illegal_out)
`endif
    );

    typedef struct {
        logic [2:0]  op;
        logic        asel, bsel, loads;
        logic [1:0]  aluop, shift;
        logic        write;
        logic [2:0]  wnum, rm, rn, rd, used;
        logic [15:0] sx;
        logic        ill;
    } m_t;

    typedef struct {
        logic [15:0] ir;
        m_t          exp;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // model state
    logic            s_vld;
    m_t              s_d;
    logic [PC_W-1:0] s_pc;
    int              cnt [8];
    m_t              cur;
    logic            e_hz, e_rdy, e_acc;

    function automatic m_t mk(int op, int asel, int bsel, int loads, int aluop, int shift,
                              int write, int wnum, int rm, int rn, int rd, int used,
                              int sx, int ill);
        m_t d;
        d.op = 3'(op); d.asel = 1'(asel); d.bsel = 1'(bsel); d.loads = 1'(loads);
        d.aluop = 2'(aluop); d.shift = 2'(shift); d.write = 1'(write); d.wnum = 3'(wnum);
        d.rm = 3'(rm); d.rn = 3'(rn); d.rd = 3'(rd); d.used = 3'(used);
        d.sx = 16'(sx); d.ill = 1'(ill);
        return d;
    endfunction

    function automatic m_t model_dec(input logic [15:0] ir);
        int op, sub, a, b, c, sh, imm8, imm5;
        op = int'(ir[15:13]); sub = int'(ir[12:11]);
        a = int'(ir[10:8]); b = int'(ir[7:5]); c = int'(ir[2:0]); sh = int'(ir[4:3]);
        imm8 = int'($signed(ir[7:0]));
        imm5 = int'($signed(ir[4:0]));
        case (op)
            6: if (sub == 2) return mk(6, 1, 1, 0, 0, 0, 1, a, 0, 0, 0, 0, imm8, 0);
               else          return mk(6, 0, 1, 0, 0, sh, 1, b, c, 0, 0, 4, 0, 0);
            5: if (sub == 1)      return mk(5, 0, 0, 1, 1, sh, 0, 0, c, a, 0, 6, 0, 0);
               else if (sub == 3) return mk(5, 0, 0, 0, 3, sh, 1, b, c, 0, 0, 4, 0, 0);
               else               return mk(5, 0, 0, 0, sub, sh, 1, b, c, a, 0, 6, 0, 0);
            4: return mk(4, 0, 1, 0, 0, 0, 0, 0, a, 0, b, 5, imm5, 0);
            3: return mk(3, 0, 1, 0, 0, 0, 1, b, a, 0, 0, 4, imm5, 0);
            0: return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            default: return mk(op, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        endcase
    endfunction

    function automatic logic [10:0] lo11(input m_t d);
        return {d.asel, d.bsel, d.loads, d.aluop, d.shift, d.write, d.wnum};
    endfunction

    function automatic int eff(input int r);
        return cnt[r] - ((wb_valid && int'(wb_num) == r && cnt[r] > 0) ? 1 : 0);
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void reset_model();
        s_vld = 1'b0;
        s_d   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s_pc  = '0;
        for (int r = 0; r < 8; r++) cnt[r] = 0;
    endfunction

    // Apply inputs just after an edge, then compare every output against the model.
    task automatic drive(input logic v, input logic [15:0] ir, input logic ordy,
                         input logic wb, input logic [2:0] wbn, input logic fl);
        in_valid = v; ir_in = ir; out_ready = ordy; wb_valid = wb; wb_num = wbn; flush = fl;
        pc_in = PC_W'($urandom);
        if (rst) reset_model();
        cur  = model_dec(ir);
        e_hz = 1'b0;
        if (v) begin
            if (cur.used[2] && eff(int'(cur.rm)) != 0) e_hz = 1'b1;
            if (cur.used[1] && eff(int'(cur.rn)) != 0) e_hz = 1'b1;
            if (cur.used[0] && eff(int'(cur.rd)) != 0) e_hz = 1'b1;
            if (cur.write && eff(int'(cur.wnum)) == SB_DEPTH) e_hz = 1'b1;
        end
        e_rdy = !fl && !e_hz && (!s_vld || ordy);
        e_acc = v && e_rdy;
        #3;
        chk("in_ready", in_ready, e_rdy);
        chk("hazard_stall", hazard_stall, e_hz && !fl);
        chk("out_valid", out_valid, s_vld);
        chk("ctrl_out", ctrl_out, {s_d.op, s_pc, lo11(s_d)});
        chk("num_rm", num_rm, s_d.rm);
        chk("num_rn", num_rn, s_d.rn);
        chk("num_rd", num_rd, s_d.rd);
        chk("used_mask", used_mask, s_d.used);
        chk("sximm", sximm, s_d.sx);
`ifdef KL_DECODE_ILLEGAL_TRAP_EN
        chk("illegal_out", illegal_out, s_d.ill);
`endif
    endtask

    task automatic adv();
        if (!rst) begin
            if (flush) begin
                s_vld = 1'b0;
                for (int r = 0; r < 8; r++) cnt[r] = 0;
            end else begin
                if (wb_valid && cnt[wb_num] > 0) cnt[wb_num]--;
                if (e_acc) begin
                    s_vld = 1'b1; s_d = cur; s_pc = pc_in;
                    if (cur.write) cnt[cur.wnum]++;
                end else if (out_ready) begin
                    s_vld = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic v, input logic [15:0] ir, input logic ordy,
                        input logic wb, input logic [2:0] wbn, input logic fl);
        drive(v, ir, ordy, wb, wbn, fl);
        adv();
    endtask

    vec_t tbl [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].ir  = 16'hD2FD; tbl[0].exp  = mk(6, 1, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 16'hFFFD, 0);
        tbl[1].ir  = 16'h8C3F; tbl[1].exp  = mk(4, 0, 1, 0, 0, 0, 0, 0, 4, 0, 1, 5, 16'hFFFF, 0);
        tbl[2].ir  = 16'hA162; tbl[2].exp  = mk(5, 0, 0, 0, 0, 0, 1, 3, 2, 1, 0, 6, 0, 0);
        tbl[3].ir  = 16'hA90A; tbl[3].exp  = mk(5, 0, 0, 1, 1, 1, 0, 0, 2, 1, 0, 6, 0, 0);
        tbl[4].ir  = 16'hB897; tbl[4].exp  = mk(5, 0, 0, 0, 3, 2, 1, 4, 7, 0, 0, 4, 0, 0);
        tbl[5].ir  = 16'h63C5; tbl[5].exp  = mk(3, 0, 1, 0, 0, 0, 1, 6, 3, 0, 0, 4, 5, 0);
        tbl[6].ir  = 16'hC02E; tbl[6].exp  = mk(6, 0, 1, 0, 0, 1, 1, 1, 6, 0, 0, 4, 0, 0);
        tbl[7].ir  = 16'hE123; tbl[7].exp  = mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[8].ir  = 16'h0000; tbl[8].exp  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9].ir  = 16'hD205; tbl[9].exp  = mk(6, 1, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 5, 0);
        tbl[10].ir = 16'hB162; tbl[10].exp = mk(5, 0, 0, 0, 2, 0, 1, 3, 2, 1, 0, 6, 0, 0);
        tbl[11].ir = 16'h3FFF; tbl[11].exp = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // reset held with an instruction on offer
        rst = 1'b1; in_valid = 1'b0; ir_in = '0; pc_in = '0; flush = 1'b0;
        wb_valid = 1'b0; wb_num = '0; out_ready = 1'b1;
        reset_model();
        drive(1, 16'hD2FD, 1, 0, 0, 0); chk("rst_out_valid", out_valid, 0); adv();
        tick(1, 16'hD2FD, 1, 0, 0, 0);
        rst = 1'b0;

        // MOV R2,#-3
        drive(1, 16'hD2FD, 1, 0, 0, 0); chk("mov_accept", in_ready, 1); adv();
        drive(0, 16'h0000, 1, 0, 0, 0);
        chk("mov_valid", out_valid, 1); chk("mov_wnum", ctrl_out[2:0], 2);
        chk("mov_sximm", sximm, 16'hFFFD); adv();
        drive(1, 16'hA162, 1, 0, 0, 0); chk("cnt2_set_stall", hazard_stall, 1); adv();

        // RAW with same-cycle writeback bypass
        tick(0, 16'h0000, 1, 0, 0, 1);
        tick(1, 16'hD205, 1, 0, 0, 0);
        drive(1, 16'hA162, 1, 0, 0, 0);
        chk("raw_stall", hazard_stall, 1); chk("raw_ready", in_ready, 0); adv();
        drive(1, 16'hA162, 1, 1, 2, 0);
        chk("raw_bypass_ready", in_ready, 1); chk("raw_bypass_stall", hazard_stall, 0); adv();

        // backpressure holds the ADD in the output register
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'hB897, 0, 0, 0, 0);
            chk("bp_ready", in_ready, 0); chk("bp_valid", out_valid, 1);
            chk("bp_rm", num_rm, 2); chk("bp_wnum", ctrl_out[2:0], 3);
            adv();
        end
        drive(1, 16'hB897, 1, 0, 0, 0); chk("bp_release", in_ready, 1); adv();
        drive(0, 16'h0000, 1, 0, 0, 0); chk("mvn_rm", num_rm, 7); adv();

        // saturation of R5 at SB_DEPTH outstanding writes
        tick(0, 16'h0000, 1, 0, 0, 1);
        for (int i = 0; i < SB_DEPTH; i++) begin
            drive(1, 16'hD501, 1, 0, 0, 0); chk("sat_fill", in_ready, 1); adv();
        end
        drive(1, 16'hD501, 1, 0, 0, 0); chk("sat_stall", hazard_stall, 1); adv();
        drive(1, 16'hD501, 1, 1, 5, 0); chk("sat_release", in_ready, 1); adv();

        // flush while an instruction is stalled
        tick(0, 16'h0000, 1, 0, 0, 1);
        tick(1, 16'hD107, 1, 0, 0, 0);
        drive(1, 16'hA162, 1, 0, 0, 0); chk("fl_pre_stall", hazard_stall, 1); adv();
        drive(1, 16'hA162, 1, 0, 0, 1);
        chk("fl_ready", in_ready, 0); chk("fl_stall", hazard_stall, 0); adv();
        drive(1, 16'hA162, 1, 0, 0, 0);
        chk("fl_out_valid", out_valid, 0); chk("fl_accept", in_ready, 1); adv();

        // writeback on an empty counter must not underflow; inc+dec in one cycle holds
        tick(0, 16'h0000, 1, 0, 0, 1);
        tick(0, 16'h0000, 1, 1, 6, 0);
        drive(1, 16'hD600, 1, 0, 0, 0); chk("no_underflow", in_ready, 1); adv();
        tick(1, 16'hD600, 1, 1, 6, 0);
        tick(1, 16'hD600, 1, 0, 0, 0);
        tick(1, 16'hD600, 1, 0, 0, 0);
        drive(1, 16'hD600, 1, 0, 0, 0); chk("incdec_sat", hazard_stall, 1); adv();

        // decode table, each entry in a cleared scoreboard
        for (int i = 0; i < 12; i++) begin
            tick(0, 16'h0000, 1, 0, 0, 1);
            tick(1, tbl[i].ir, 1, 0, 0, 0);
            drive(0, 16'h0000, 0, 0, 0, 0);
            chk($sformatf("tbl%0d_valid", i), out_valid, 1);
            chk($sformatf("tbl%0d_ctrl", i), {ctrl_out[13+PC_W -: 3], ctrl_out[10:0]},
                {tbl[i].exp.op, lo11(tbl[i].exp)});
            chk($sformatf("tbl%0d_regs", i), {num_rm, num_rn, num_rd, used_mask},
                {tbl[i].exp.rm, tbl[i].exp.rn, tbl[i].exp.rd, tbl[i].exp.used});
            chk($sformatf("tbl%0d_sximm", i), sximm, tbl[i].exp.sx);
`ifdef KL_DECODE_ILLEGAL_TRAP_EN
            chk($sformatf("tbl%0d_illegal", i), illegal_out, tbl[i].exp.ill);
`endif
            adv();
        end

        // randomized traffic, with one asynchronous reset mid-run
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) rst = 1'b1;
            tick(($urandom % 4) != 0, 16'($urandom), ($urandom % 4) != 0,
                 ($urandom % 2) != 0, 3'($urandom), ($urandom % 40) == 0);
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage_sb.md
Name: decode_stage_sb

Overview:
- Registered, parametrised successor to the stage-0 combinational decoder.
- Decodes one 16-bit instruction per cycle into the same control bundle, held in a single output register with a valid/ready handshake.
- Adds a per-register scoreboard of in-flight writes. Instructions with RAW hazards, or whose destination counter is saturated, are held at the input until writeback clears them.
- Sits between instruction fetch and the register-read/execute stage.

Parameters:
- PC_W, 8, width of instruction address.
- DATA_W, 16, width of sximm; must be ≥8.
- SB_DEPTH, 3, maximum outstanding writes tracked per register (counter width CW=$clog2(SB_DEPTH+1)).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch offers ir_in/pc_in.
- in_ready  out  1  stage accepts this cycle.
- ir_in  in  16  instruction.
- pc_in  in  PC_W  instruction address.
- flush  in  1  kill held output and clear scoreboard.
- wb_valid  in  1  a register write retires this cycle.
- wb_num  in  3  retiring destination register.
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  downstream consumes.
- ctrl_out  out  14+PC_W  {opcode[2:0], pc, asel, bsel, loads, aluop[1:0], shift[1:0], write, writenum[2:0]}.
- num_rm, num_rn, num_rd  out  3 each  source register numbers.
- used_mask  out  3  bit2=rm, bit1=rn, bit0=rd read.
- sximm  out  DATA_W  sign-extended immediate.
- hazard_stall  out  1  in_valid blocked by scoreboard this cycle.

Behaviour:
- Decode (combinational on ir_in). opcode=ir[15:13]. Unlisted fields are 0.
- 000 NOP: all zero.
- 110 with ir[12:11]=10, MOV imm: asel=bsel=1, write=1, writenum=ir[10:8], sximm=sext(ir[7:0]), used=000.
- 110 otherwise, MOV reg: bsel=1, write=1, writenum=ir[7:5], shift=ir[4:3], rm=ir[2:0], used=100.
- 101 ALU: aluop=ir[12:11], shift=ir[4:3], rm=ir[2:0].
  - 00/10 ADD/AND: rn=ir[10:8], write=1, writenum=ir[7:5], used=110.
  - 01 CMP: rn=ir[10:8], loads=1, write=0, used=110.
  - 11 MVN: write=1, writenum=ir[7:5], used=100.
- 100 STR: bsel=1, rm=ir[10:8] (base), rd=ir[7:5], sximm=sext(ir[4:0]), used=101.
- 011 LDR: bsel=1, rm=ir[10:8], write=1, writenum=ir[7:5], sximm=sext(ir[4:0]), used=100.
- 001/010/111: decoded as NOP.
- Scoreboard: cnt[0..7], each CW bits. Effective count eff[r] = cnt[r] − (wb_valid && wb_num==r), i.e. same-cycle writeback bypass.
- hazard = in_valid && (any used source with eff≠0, or write && eff[writenum]==SB_DEPTH).
- in_ready = !flush && !hazard && (!out_valid || out_ready). hazard_stall = in_valid && hazard && !flush.
- Accept (in_valid && in_ready): output register loads the decode at the next edge; out_valid=1. If write=1, cnt[writenum] increments.
- Same-register increment and decrement in one cycle: count unchanged.
- wb_valid with cnt==0: ignored, no underflow.
- out_valid drops when out_ready && !accept.
- Latency 1 cycle input→output; throughput 1/cycle.
- Outputs are stable while out_valid && !out_ready.
- flush: at the next edge out_valid=0 and all cnt=0. It overrides accept and wb in the same cycle.
- Reset (async): out_valid=0, all output fields 0, all cnt=0. Reset mid-operation discards the held instruction.

Optional Feature:
- Macro KL_DECODE_ILLEGAL_TRAP_EN.
- Defined: adds output illegal_out (1 bit, registered with the bundle, reset 0). Opcodes 001/010/111 set it, with write=0.
- Undefined: port absent; such opcodes are silent NOPs.

Decomposition:
- Package kl_decode_pkg: opcode localparams (OP_NOP, OP_LDR, OP_STR, OP_ALU, OP_MOV), ALU op codes, the ctrl_out field offsets, and a packed struct for the decode bundle.
- Sub-module kl_scoreboard: counters, bypassed eff[] compare, inc/dec/flush.

Test Plan:
- Reset with in_valid=1 → out_valid=0, cnt all 0. After release, MOV R2,#-3 (0xD2FD) → next cycle out_valid=1, writenum=2, sximm=0xFFFD, cnt[2]=1.
- RAW: MOV R2,#5 then ADD R3,R1,R2 → ADD stalls (hazard_stall=1). With wb_valid, wb_num=2 in the same cycle, ADD is accepted that cycle.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 → in_ready=0, outputs constant, no counter change.
- Saturation: four independent MOV R5 with no writeback, SB_DEPTH=3 → fourth stalls; one wb of R5 releases it.
- Flush during stall → out_valid=0 next cycle, cnt all 0, stalled instruction accepted the cycle after.
- STR R1,[R4,#-1] (0x8C3F) → rm=4, rd=1, used=101, sximm=0xFFFF, write=0. Opcode 111 → NOP, plus illegal_out=1 when KL_DECODE_ILLEGAL_TRAP_EN is defined.
